// File: rtl/ssyser_pkg.sv
// Shared defaults and state encoding for the oversampled serial transmitter.
package ssyser_pkg;
    localparam int W_DEF      = 66;
    localparam int PERIOD_DEF = 8;

    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/ssyser_uitimer.sv
// Unit-interval timer: UI phase counter, boundary strobe and mid-UI forwarded clock.
module ssyser_uitimer #(
    parameter int PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    output logic b,
    output logic out_clk
);
    localparam int UW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [UW-1:0] LAST = UW'(PERIOD - 1);
    localparam logic [UW-1:0] HALF = UW'(PERIOD / 2);

    if ((PERIOD < 2) || ((PERIOD % 2) != 0)) begin : g_bad_period
        $error("ssyser_uitimer: PERIOD must be even and >= 2");
    end

    logic [UW-1:0] uicnt;
    logic [UW-1:0] uicnt_next;

    assign b          = (uicnt == LAST);
    assign uicnt_next = b ? '0 : uicnt + 1'b1;

    // out_clk is registered from the next phase so it rises exactly PERIOD/2 cycles into each UI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uicnt   <= '0;
            out_clk <= 1'b0;
        end else begin
            uicnt   <= uicnt_next;
            out_clk <= (uicnt_next >= HALF);
        end
    end
endmodule

// File: rtl/ssyser.sv
// Oversampled LSB-first serializer with a one-entry holding buffer and alternating idle fill.
module ssyser
    import ssyser_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_block,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_data,
    output logic         out_clk,
    output logic         underrun
);
    localparam int BW = $clog2(W);
    localparam logic [BW-1:0] BLAST = BW'(W - 1);

    logic          b;
    logic [W-1:0]  buf_q;
    logic          buf_full;
    logic [W-1:0]  shreg, shreg_n;
    logic [BW-1:0] bitcnt, bitcnt_n;
    state_t        state, state_n;
    logic          out_data_n;
    logic          underrun_n;
    logic          load;
    logic          accept;

    ssyser_uitimer #(.PERIOD(PERIOD)) u_uitimer (
        .clk     (clk),
        .rst     (rst),
        .b       (b),
        .out_clk (out_clk)
    );

    assign in_ready = !buf_full;
    assign accept   = in_valid && !buf_full;

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bitcnt_n   = bitcnt;
        out_data_n = out_data;
        underrun_n = 1'b0;
        load       = 1'b0;
        if (b) begin
            case (state)
                IDLE: begin
                    if (buf_full) load = 1'b1;
                    else          out_data_n = !out_data;
                end
                SHIFT: begin
                    if (bitcnt != BLAST) begin
                        out_data_n = shreg[0];
                        shreg_n    = shreg >> 1;
                        bitcnt_n   = bitcnt + 1'b1;
                    end else if (buf_full) begin
                        load = 1'b1;
                    end else begin
                        out_data_n = !out_data;
                        underrun_n = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // bit 0 goes straight to the line, the rest waits in the shifter
        if (load) begin
            out_data_n = buf_q[0];
            shreg_n    = buf_q >> 1;
            bitcnt_n   = '0;
            state_n    = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            out_data <= 1'b0;
            underrun <= 1'b0;
            buf_q    <= '0;
            buf_full <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            out_data <= out_data_n;
            underrun <= underrun_n;
            // accept needs an empty buffer and load a full one, so they never coincide
            if (accept) begin
                buf_q    <= in_block;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ssyser.sv
// Self-checking bench for ssyser: UI-level reference model, literal pins, clock-recovery loopback.
module tb_ssyser;
    localparam int W      = 66;
    localparam int PERIOD = 8;
    localparam int HALF   = PERIOD / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_block = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, out_data, out_clk, underrun;

    always #5 clk = ~clk;

    ssyser #(.W(W), .PERIOD(PERIOD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_block (in_block),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_clk  (out_clk),
        .underrun (underrun)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_blk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_blk();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Reference model: cycle index since reset, UI k = cycles k*PERIOD..k*PERIOD+PERIOD-1,
    // a queue of bits still to send, and a one-deep buffer.
    int           cyc;
    logic         m_out, m_und, m_full, m_indata;
    logic [W-1:0] m_buf;
    bit           bitq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_out = 0; m_und = 0; m_full = 0; m_indata = 0;
            bitq.delete();
        end else begin
            logic acc;
            acc   = in_valid && !m_full;
            m_und = 0;
            if (cyc % PERIOD == PERIOD - 1) begin
                if (bitq.size() > 0) begin
                    m_out = bitq.pop_front();
                end else if (m_full) begin
                    for (int i = 0; i < W; i++) bitq.push_back(m_buf[i]);
                    m_out    = bitq.pop_front();
                    m_full   = 0;
                    m_indata = 1;
                end else begin
                    if (m_indata) m_und = 1;
                    m_indata = 0;
                    m_out    = !m_out;
                end
            end
            if (acc) begin
                m_buf  = in_block;
                m_full = 1;
            end
            cyc++;
        end
    end

    // Observation records and clock-recovery model
    logic         samp [0:99];
    logic         clkv [0:15];
    int           und_cnt, und_cyc;
    logic [W-1:0] acc_log[$];
    logic         cr_en = 1'b0;
    logic         prev_d, prev_c;
    int           cr_tr, run, min_run, max_run, rises, last_rise, minp, maxp;

    always @(negedge clk) begin
        if (rst) begin
            und_cnt = 0;
            und_cyc = -1;
        end else begin
            check_bit("out_data", out_data, m_out);
            check_bit("out_clk", out_clk, (cyc % PERIOD) >= HALF);
            check_bit("underrun", underrun, m_und);
            check_bit("in_ready", in_ready, !m_full);
            if (cyc % PERIOD == HALF && cyc / PERIOD < 100) samp[cyc / PERIOD] = out_data;
            if (cyc < 16) clkv[cyc] = out_clk;
            if (underrun) begin und_cnt++; und_cyc = cyc; end
            if (in_valid && in_ready) acc_log.push_back(in_block);
            if (!cr_en) begin
                cr_tr = 0; run = 0; min_run = 1000; max_run = -1;
                rises = 0; minp = 1000; maxp = -1; last_rise = 0;
            end else begin
                if (out_data != prev_d) begin
                    cr_tr++;
                    if (cr_tr >= 2) begin
                        if (run < min_run) min_run = run;
                        if (run > max_run) max_run = run;
                    end
                    run = 0;
                end else begin
                    run++;
                end
                if (out_clk && !prev_c) begin
                    if (rises > 0) begin
                        if (cyc - last_rise < minp) minp = cyc - last_rise;
                        if (cyc - last_rise > maxp) maxp = cyc - last_rise;
                    end
                    rises++;
                    last_rise = cyc;
                end
            end
            prev_d = out_data;
            prev_c = out_clk;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] blk);
        int n;
        n        = 0;
        in_block = blk;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_bit("send_accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        logic [W-1:0] x, y, blks[3], a;
        // Reset state and idle pattern
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) check_bit("idle_ui_level", samp[i], logic'(i % 2));
        check_bit("oclk_c3", clkv[3], 1'b0);
        check_bit("oclk_c4", clkv[4], 1'b1);
        check_bit("oclk_c7", clkv[7], 1'b1);
        check_bit("oclk_c8", clkv[8], 1'b0);
        check_int("idle_no_underrun", und_cnt, 0);

        // Single literal block: accepted at end of cycle 0, bit 0 in UI 1
        do_reset();
        send(66'h3_0000_0000_0000_0005);
        repeat (600) @(posedge clk);
        #1;
        check_bit("single_pre_idle", samp[0], 1'b0);
        for (int i = 0; i < W; i++)
            check_bit("single_bit", samp[i + 1], (i == 0 || i == 2 || i == 64 || i == 65));
        check_bit("single_post_idle0", samp[67], 1'b0);
        check_bit("single_post_idle1", samp[68], 1'b1);
        check_int("single_und_cnt", und_cnt, 1);
        check_int("single_und_cyc", und_cyc, 8 + W * PERIOD);

        // Back-to-back: 132 contiguous data UIs, one underrun at the end
        do_reset();
        x = rnd_blk();
        y = rnd_blk();
        send(x);
        send(y);
        repeat (1100) @(posedge clk);
        #1;
        check_int("b2b_und_cnt", und_cnt, 1);
        check_int("b2b_und_cyc", und_cyc, 8 + 2 * W * PERIOD);

        // Backpressure: three blocks, accepted once each and in order
        do_reset();
        acc_log.delete();
        for (int i = 0; i < 3; i++) blks[i] = rnd_blk();
        send(blks[0]);
        check_bit("bp_ready_drop", in_ready, 1'b0);
        send(blks[1]);
        send(blks[2]);
        repeat (3 * W * PERIOD + 100) @(posedge clk);
        #1;
        check_int("bp_accept_count", acc_log.size(), 3);
        for (int i = 0; i < 3 && i < acc_log.size(); i++) check_blk("bp_accept_order", acc_log[i], blks[i]);
        check_int("bp_und_cnt", und_cnt, 1);

        // Randomized gaps and blocks against the model
        do_reset();
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 300)) @(posedge clk);
            #1;
            send(rnd_blk());
        end
        repeat (1500) @(posedge clk);
        #1;

        // Async reset at bit 30 with the buffer full, then idle-only loopback
        do_reset();
        a = rnd_blk();
        a[30] = 1'b1;
        send(a);
        send(rnd_blk());
        check_bit("rst_buf_full", in_ready, 1'b0);
        repeat (244) @(posedge clk);
        #3;
        check_bit("pre_rst_data_bit30", out_data, 1'b1);
        check_bit("pre_rst_oclk", out_clk, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("async_rst_data", out_data, 1'b0);
        check_bit("async_rst_oclk", out_clk, 1'b0);
        check_bit("async_rst_underrun", underrun, 1'b0);
        check_bit("async_rst_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cr_en = 1'b1;
        repeat (60 * PERIOD) @(posedge clk);
        #1;
        check_bit("cr_enough_transitions", cr_tr >= 50, 1'b1);
        check_int("cr_min_run", min_run, PERIOD - 1);
        check_int("cr_max_run", max_run, PERIOD - 1);
        check_int("cr_min_period", minp, PERIOD);
        check_int("cr_max_period", maxp, PERIOD);
        check_int("post_rst_no_underrun", und_cnt, 0);
        cr_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ssyser.md
# ssyser

Oversampled serial transmitter for the 25G PCS bench: accepts 66-bit blocks over a valid/ready handshake and serializes them LSB-first onto a single-bit line. Each unit interval (UI) lasts PERIOD cycles of the fast bench clock. When no block is available, it drives an alternating idle pattern so a downstream clock-recovery model always sees transitions. It also emits a forwarded bit clock centred in each UI, for checking recovered clocks against the transmit reference.

## Interface
Parameters:
- W, 66, block width in bits
- PERIOD, 8, clk cycles per UI; even, ≥2 (elaboration error otherwise)

Ports:
- clk  in  1  fast oversampling clock
- rst  in  1  reset; asynchronous, active-high
- in_block  in  W  block to transmit, bit 0 sent first
- in_valid  in  1  in_block valid
- in_ready  out  1  holding buffer empty; a block is accepted on any posedge with in_valid && in_ready
- out_data  out  1  serial line
- out_clk  out  1  forwarded bit clock, rising at mid-UI
- underrun  out  1  one-cycle pulse when a block ends with no successor buffered

## Operation
- Datapath: one-entry holding buffer (buf, buf_full); shift register shreg[W-1:0]; bitcnt 0..W-1; uicnt 0..PERIOD-1; state ∈ {IDLE, SHIFT}.
- Widths: uicnt is $clog2(PERIOD) bits and bitcnt is $clog2(W) bits; both wrap explicitly at their terminal value, never by overflow.
- in_ready = !buf_full (registered state, no combinational path from in_valid).
- Accept: on valid && ready, buf ← in_block and buf_full ← 1.
- Boundary strobe b = (uicnt == PERIOD-1). Every edge with b is a UI boundary, at which out_data updates.
- IDLE at boundary:
  - buf_full: out_data ← buf[0], shreg ← buf >> 1, bitcnt ← 0, buf_full ← 0, state ← SHIFT.
  - otherwise: out_data ← !out_data (idle toggle).
- SHIFT at boundary:
  - bitcnt < W-1: out_data ← shreg[0], shreg ← shreg >> 1, bitcnt++.
  - bitcnt == W-1 and buf_full: seamless reload exactly as from IDLE; no gap UI and no underrun.
  - bitcnt == W-1 and !buf_full: out_data ← !out_data, underrun pulses high for one cycle, state ← IDLE.
- Simultaneous events:
  - Accept and load on the same edge cannot collide, because accept requires buf_full = 0 and load requires buf_full = 1.
  - A block accepted on a boundary edge is loaded at the next boundary, not the current one.
- out_clk = registered (uicnt_next ≥ PERIOD/2). It is low for the first half of each UI and high for the second half.
- Reset (asynchronous, any time including mid-block):
  - out_data = 0, out_clk = 0, underrun = 0, in_ready = 1.
  - buf_full = 0 (a buffered block is discarded), state = IDLE, uicnt = 0, bitcnt = 0.
  - Transmission restarts with idle after release.

## Timing
- uicnt advances every cycle after reset release; UI k spans cycles k·PERIOD .. k·PERIOD+PERIOD-1.
- Latency: a block accepted at edge t has bit 0 on out_data from the first boundary edge strictly after t. The latency is 1..PERIOD cycles from IDLE, or up to the remaining block time from SHIFT.
- in_ready returns high on the cycle after the load edge.
- underrun is asserted on the same edge out_data switches to idle.
- out_data changes only on boundary edges; out_clk rises PERIOD/2 cycles after each boundary.

## Structure
- Package ssyser_pkg:
  - localparams W_DEF = 66 and PERIOD_DEF = 8.
  - state enum {IDLE, SHIFT}.
- Sub-module ssyser_uitimer: owns uicnt, the boundary strobe and out_clk; parameter PERIOD.
- Top level owns the buffer, shifter, bit counter and state machine.

## Test plan
- Reset, no input, PERIOD=8:
  - out_data is 0 for cycles 0-7, 1 for 8-15, 0 for 16-23, and so on.
  - out_clk is high on cycles 4-7 of each UI.
  - underrun is never asserted.
- Single block 66'h3_0000_0000_0000_0005:
  - Bit sequence 1,0,1, then 0×61, then 1,1, each held 8 cycles.
  - Followed by one underrun pulse, then idle toggling resumes (first idle level = !last bit = 0).
- Back-to-back blocks: two blocks presented with in_valid held → 132 contiguous data UIs, no gap, and exactly one underrun, after the second block.
- Backpressure: three blocks on held in_valid:
  - in_ready drops the cycle after the first accept.
  - It rises the cycle after each load edge.
  - Each block is accepted exactly once, in order.
- Async reset asserted mid-block (bit 30) with the buffer full:
  - Outputs go to their reset values immediately, without waiting for clk.
  - After release, idle only; the discarded blocks never appear.
- Loopback into the bench clock-recovery model on the same clk, ≥50 transitions of idle:
  - Recovered minimum run-length count settles to PERIOD-1 = 7.
  - Recovered clock period is 8 cycles.
